run_sequencer: RTL and testbench

Host-side launch controller that sits directly upstream of the processor top level. It holds the core in reset, then issues its single-cycle `req` and times the run until the core raises `done`. It reports completion, elapsed cycles and timeout to the host (testbench or SoC wrapper). All core-facing outputs are registered, so the core sees clean, glitch-free `reset`/`req`.

---
 rtl/run_sequencer.sv | 123 ++++++++++++
 tb/tb_run_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// Launch controller: holds the core in reset, issues a one-cycle req, then times the run until done or timeout.
// Optional abort path is compiled in with `define RUN_SEQ_ABORT_EN.
module run_sequencer #(
   parameter int CYC_WIDTH  = 16,
   parameter int RST_CYCLES = 4,
   parameter int TIMEOUT    = 4000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 core_done,
   output logic                 core_reset,
   output logic                 core_req,
   output logic                 busy,
   output logic                 finished,
   output logic                 timed_out,
   output logic [CYC_WIDTH-1:0] cycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_LAUNCH,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [7:0]           RST_LAST = 8'(RST_CYCLES - 1);
   localparam logic [CYC_WIDTH-1:0] TO_LAST  = CYC_WIDTH'(TIMEOUT - 1);
   localparam logic [CYC_WIDTH-1:0] TO_VALUE = CYC_WIDTH'(TIMEOUT);
   localparam logic [CYC_WIDTH-1:0] CYC_MAX  = '1;
   localparam logic [CYC_WIDTH-1:0] CYC_ONE  = CYC_WIDTH'(1);

   state_t               state_reg, state_next;
   logic [7:0]           rst_cnt_reg, rst_cnt_next;
   logic [CYC_WIDTH-1:0] cycles_reg, cycles_next;
   logic                 timed_out_reg, timed_out_next;
   logic                 abort_req;

`ifdef RUN_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   logic unused_abort;
   assign unused_abort = abort;
   assign abort_req    = 1'b0;
`endif

   always_comb begin
      state_next     = state_reg;
      rst_cnt_next   = rst_cnt_reg;
      cycles_next    = cycles_reg;
      timed_out_next = timed_out_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next     = S_RESET;
               cycles_next    = '0;
               timed_out_next = 1'b0;
               rst_cnt_next   = '0;
            end
         end
         S_RESET: begin
            if (abort_req)
               state_next = S_IDLE;
            else if (rst_cnt_reg == RST_LAST)
               state_next = S_LAUNCH;
            else
               rst_cnt_next = rst_cnt_reg + 8'd1;
         end
         S_LAUNCH: begin
            state_next = abort_req ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            // Priority: abort, then done, then timeout; done in the timeout cycle still wins.
            if (abort_req) begin
               state_next = S_IDLE;
            end else if (core_done) begin
               state_next = S_DONE;
            end else if (TIMEOUT != 0 && cycles_reg == TO_LAST) begin
               cycles_next    = TO_VALUE;
               timed_out_next = 1'b1;
               state_next     = S_DONE;
            end else if (cycles_reg != CYC_MAX) begin
               cycles_next = cycles_reg + CYC_ONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so the core sees them as clean flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         rst_cnt_reg   <= '0;
         cycles_reg    <= '0;
         timed_out_reg <= 1'b0;
         core_reset    <= 1'b1;
         core_req      <= 1'b0;
         busy          <= 1'b0;
         finished      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         rst_cnt_reg   <= rst_cnt_next;
         cycles_reg    <= cycles_next;
         timed_out_reg <= timed_out_next;
         core_reset    <= (state_next == S_IDLE) || (state_next == S_RESET) || (state_next == S_DONE);
         core_req      <= (state_next == S_LAUNCH);
         busy          <= (state_next == S_RESET) || (state_next == S_LAUNCH) || (state_next == S_RUN);
         finished      <= (state_next == S_DONE);
      end
   end

   assign timed_out = timed_out_reg;
   assign cycles    = cycles_reg;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: table of runs checked through an expected-result queue, plus
// hand sequences for back-to-back starts, abort and asynchronous reset.
module tb_run_sequencer;

   localparam int CW = 16;
   localparam int RC = 4;
   localparam int TO = 20;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          core_done = 1'b0;
   logic          core_reset, core_req, busy, finished, timed_out;
   logic [CW-1:0] cycles;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int cyc;
      bit to;
   } exp_t;

   typedef struct {
      int done_at;
      bit start_in_run;
      int exp_cycles;
      bit exp_to;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];
   logic prev_req = 1'b0;

   run_sequencer #(.CYC_WIDTH(CW), .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .abort(abort),
      .core_done(core_done),
      .core_reset(core_reset),
      .core_req(core_req),
      .busy(busy),
      .finished(finished),
      .timed_out(timed_out),
      .cycles(cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Scoreboard: every completion pulse pops one expected result.
   always @(negedge clk) begin : sb_mon
      exp_t e;
      if (reset === 1'b1 && finished === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_finished actual=1 expected=0");
         end else begin
            e = sb.pop_front();
            check("sb_cycles", 32'(cycles), e.cyc);
            check("sb_timed_out", 32'(timed_out), 32'(e.to));
            check("done_core_reset", 32'(core_reset), 1);
            check("done_busy", 32'(busy), 0);
            $display("run done: cycles=%0d timed_out=%0b", cycles, timed_out);
         end
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b1 && core_req === 1'b1) begin
         check("req_width", 32'(prev_req), 0);
         check("req_core_reset", 32'(core_reset), 0);
      end
      prev_req = core_req;
   end

   task automatic run_one(input vec_t v);
      int  n, req_at, run_idx;
      bit  got;
      @(negedge clk);
      start = 1'b1;
      sb.push_back('{v.exp_cycles, v.exp_to});
      @(negedge clk);
      start = 1'b0;
      check("rst_entry_busy", 32'(busy), 1);
      check("rst_entry_core_reset", 32'(core_reset), 1);
      check("rst_entry_timed_out", 32'(timed_out), 0);
      check("rst_entry_cycles", 32'(cycles), 0);
      n = 1;
      req_at = -1;
      run_idx = -1;
      got = 1'b0;
      while (n < 200 && !got) begin
         if (core_req) begin
            req_at = n;
         end else if (req_at >= 0 && busy) begin
            run_idx++;
            if (run_idx == v.done_at) core_done = 1'b1;
            start = (v.start_in_run && run_idx == 3);
         end
         if (finished) got = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      core_done = 1'b0;
      start = 1'b0;
      check("finish_seen", 32'(got), 1);
      check("req_latency", req_at, RC + 1);
      @(negedge clk);
      check("idle_hold_cycles", 32'(cycles), v.exp_cycles);
      check("idle_busy", 32'(busy), 0);
      check("idle_core_reset", 32'(core_reset), 1);
      if (v.start_in_run) begin
         repeat (3) @(negedge clk);
         check("no_queued_start", 32'(busy), 0);
      end
   endtask

   // Starts a run and returns at the negedge of RUN cycle idx.
   task automatic start_to_run(input int idx);
      int n;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!core_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_wait", 32'(core_req), 1);
      repeat (idx + 1) @(negedge clk);
   endtask

   initial begin : main
      int n, req_cnt, fin_cnt, fin_n, run_idx, k;
      vecs[0] = '{10, 1'b0, 10, 1'b0};
      vecs[1] = '{-1, 1'b0, 20, 1'b1};
      vecs[2] = '{19, 1'b0, 19, 1'b0};
      vecs[3] = '{0,  1'b0, 0,  1'b0};
      vecs[4] = '{10, 1'b1, 10, 1'b0};
      vecs[5] = '{18, 1'b0, 18, 1'b0};

      repeat (2) @(negedge clk);
      check("rst_core_reset", 32'(core_reset), 1);
      check("rst_core_req", 32'(core_req), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_finished", 32'(finished), 0);
      check("rst_timed_out", 32'(timed_out), 0);
      check("rst_cycles", 32'(cycles), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) run_one(vecs[i]);

      // Held start: three runs, each gap is DONE + IDLE + RESET before the next req.
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back('{2, 1'b0});
      n = 0; req_cnt = 0; fin_cnt = 0; fin_n = 0; run_idx = -1;
      while (fin_cnt < 3 && n < 300) begin
         @(negedge clk);
         n++;
         if (core_req) begin
            req_cnt++;
            run_idx = -1;
            if (req_cnt > 1) check("b2b_gap", n - fin_n, RC + 2);
            if (req_cnt == 3) start = 1'b0;
         end else if (busy && !core_reset) begin
            run_idx++;
            core_done = (run_idx == 2);
         end
         if (finished) begin
            fin_cnt++;
            fin_n = n;
            core_done = 1'b0;
         end
      end
      check("b2b_reqs", req_cnt, 3);
      check("b2b_finishes", fin_cnt, 3);
      req_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (core_req) req_cnt++;
      end
      check("b2b_no_extra", req_cnt, 0);

      // Abort at RUN cycle 5.
`ifndef RUN_SEQ_ABORT_EN
      sb.push_back('{12, 1'b0});
`endif
      start_to_run(5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
`ifdef RUN_SEQ_ABORT_EN
      check("abort_busy", 32'(busy), 0);
      check("abort_core_reset", 32'(core_reset), 1);
      check("abort_finished", 32'(finished), 0);
      check("abort_cycles", 32'(cycles), 5);
      repeat (3) @(negedge clk);
      check("abort_stays_idle", 32'(busy), 0);
`else
      k = 6;
      if (k == 12) core_done = 1'b1;
      while (!finished && k < 100) begin
         @(negedge clk);
         k++;
         if (k == 12) core_done = 1'b1;
      end
      core_done = 1'b0;
      check("abort_ignored_fin", 32'(finished), 1);
      check("abort_ignored_cycles", 32'(cycles), 12);
      @(negedge clk);
`endif

      // Asynchronous reset mid-RUN.
      start_to_run(7);
      check("pre_reset_cycles", 32'(cycles), 7);
      reset = 1'b0;
      #1;
      check("async_core_reset", 32'(core_reset), 1);
      check("async_core_req", 32'(core_req), 0);
      check("async_busy", 32'(busy), 0);
      check("async_cycles", 32'(cycles), 0);
      check("async_timed_out", 32'(timed_out), 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("post_reset_idle", 32'(busy), 0);
      check("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
